// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write priority, optional zero register,
// optional write-to-read forwarding and a per-register pending-writeback scoreboard.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      we,
    input  logic [NUM_WR*AW-1:0]   waddr,
    input  logic [NUM_WR*XLEN-1:0] wdata,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr,
    output logic [DEPTH-1:0]       busy_vec
);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;

    // Clears from writebacks are applied before the alloc so a new producer wins.
    always_comb begin
        w_busy_next = r_busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (we[j]) begin
                w_busy_next[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_en) begin
            w_busy_next[alloc_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_busy_next[0] = 1'b0;
        end
    end

    // Ports are visited in ascending order, so the highest-numbered port's write lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (we[j] && !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0))) begin
                    r_mem[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                end
            end
            r_busy <= w_busy_next;
        end
    end

    assign busy_vec = r_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;
            logic            w_hit;
            logic            w_busy;

            assign w_addr = rd_addr[gi*AW +: AW];

            always_comb begin
                w_data = r_mem[w_addr];
                w_hit  = 1'b0;
                if (BYPASS != 0) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (we[j] && (waddr[j*AW +: AW] == w_addr)) begin
                            w_data = wdata[j*XLEN +: XLEN];
                            w_hit  = 1'b1;
                        end
                    end
                end
                w_busy = r_busy[w_addr] & ~w_hit;
                if ((ZERO_REG != 0) && (w_addr == '0)) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = w_data;
            assign rd_busy[gi]              = w_busy;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a forwarding instance and a non-forwarding instance share
// stimulus and are compared against an array-based reference model.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*AW-1:0] rd_addr;
    logic [63:0]     rd_data, rd_data_nb;
    logic [1:0]      rd_busy, rd_busy_nb;
    logic [1:0]      we;
    logic [2*AW-1:0] waddr;
    logic [63:0]     wdata;
    logic            alloc_en;
    logic [AW-1:0]   alloc_addr;
    logic [31:0]     busy_vec, busy_vec_nb;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_mem  [DEPTH];
    logic        m_busy [DEPTH];

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .busy_vec(busy_vec)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .we(we), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .busy_vec(busy_vec_nb)
    );

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we[1] && waddr[AW +: AW] == a) return wdata[32 +: 32];
        if (byp && we[0] && waddr[0 +: AW] == a) return wdata[0 +: 32];
        return m_mem[a];
    endfunction

    function automatic logic exp_rbusy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && ((we[1] && waddr[AW +: AW] == a) || (we[0] && waddr[0 +: AW] == a)))
            return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [31:0] exp_bvec();
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic idle();
        rst = 1'b0; we = 2'b00; waddr = '0; wdata = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    // Advance one edge and apply the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (we[j] && waddr[j*AW +: AW] != 0)
                    m_mem[waddr[j*AW +: AW]] = wdata[j*32 +: 32];
                if (we[j]) m_busy[waddr[j*AW +: AW]] = 1'b0;
            end
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1;
        we = 2'b11; waddr = {5'd3, 5'd2}; wdata = {32'h1, 32'h2}; alloc_en = 1'b1; alloc_addr = 5'd6;
        tick();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            n_checks++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00)
                $display("FAIL reset_read addr=%0d data=%h busy=%b want 0/00", a, rd_data, rd_busy);
            else n_pass++;
        end
        n_checks++;
        if (busy_vec !== 32'h0 || busy_vec_nb !== 32'h0)
            $display("FAIL reset_busy_vec got %h/%h want 0", busy_vec, busy_vec_nb);
        else n_pass++;
        $display("test_reset: all addresses read back");
    endtask

    task automatic test_write_read();
        idle(); we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
        tick();
        idle(); rd_addr = {5'd5, 5'd0}; #1;
        n_checks++;
        if (rd_data[32 +: 32] !== 32'hDEADBEEF || rd_data_nb[32 +: 32] !== 32'hDEADBEEF)
            $display("FAIL write_read x5 got %h/%h want deadbeef", rd_data[32 +: 32], rd_data_nb[32 +: 32]);
        else n_pass++;
        we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'h1234}; rd_addr = {5'd0, 5'd0}; #1;
        n_checks++;
        if (rd_data[0 +: 32] !== 32'h0)
            $display("FAIL zero_bypass x0 got %h want 0", rd_data[0 +: 32]);
        else n_pass++;
        tick();
        idle(); #1;
        n_checks++;
        if (rd_data !== 64'h0 || rd_data_nb !== 64'h0)
            $display("FAIL zero_reg x0 got %h/%h want 0", rd_data, rd_data_nb);
        else n_pass++;
        $display("test_write_read: x5=deadbeef, x0 stays 0");
    endtask

    task automatic test_bypass();
        idle(); rd_addr = {5'd0, 5'd7};
        we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'hA5A5A5A5}; #1;
        n_checks++;
        if (rd_data[0 +: 32] !== 32'hA5A5A5A5)
            $display("FAIL bypass_same_cycle got %h want a5a5a5a5", rd_data[0 +: 32]);
        else n_pass++;
        n_checks++;
        if (rd_data_nb[0 +: 32] !== 32'h0)
            $display("FAIL nobypass_old got %h want 0", rd_data_nb[0 +: 32]);
        else n_pass++;
        tick();
        idle(); #1;
        n_checks++;
        if (rd_data_nb[0 +: 32] !== 32'hA5A5A5A5)
            $display("FAIL nobypass_new got %h want a5a5a5a5", rd_data_nb[0 +: 32]);
        else n_pass++;
        $display("test_bypass: x7 forwarding checked");
    endtask

    task automatic test_dual_write();
        idle(); rd_addr = {5'd0, 5'd3};
        we = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11}; #1;
        n_checks++;
        if (rd_data[0 +: 32] !== 32'h22)
            $display("FAIL dual_bypass got %h want 22", rd_data[0 +: 32]);
        else n_pass++;
        tick();
        idle(); #1;
        n_checks++;
        if (rd_data[0 +: 32] !== 32'h22 || rd_data_nb[0 +: 32] !== 32'h22)
            $display("FAIL dual_stored got %h/%h want 22", rd_data[0 +: 32], rd_data_nb[0 +: 32]);
        else n_pass++;
        $display("test_dual_write: port 1 wins on x3");
    endtask

    task automatic test_scoreboard();
        idle(); alloc_en = 1'b1; alloc_addr = 5'd9;
        tick();
        idle(); rd_addr = {5'd9, 5'd9}; #1;
        n_checks++;
        if (busy_vec[9] !== 1'b1 || rd_busy !== 2'b11)
            $display("FAIL alloc_busy vec9=%b rd_busy=%b want 1/11", busy_vec[9], rd_busy);
        else n_pass++;
        we = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99}; #1;
        n_checks++;
        if (rd_busy !== 2'b00 || rd_data !== {32'h99, 32'h99})
            $display("FAIL wb_bypass rd_busy=%b data=%h want 00/99", rd_busy, rd_data);
        else n_pass++;
        n_checks++;
        if (rd_busy_nb !== 2'b11)
            $display("FAIL wb_nobypass_busy got %b want 11", rd_busy_nb);
        else n_pass++;
        tick();
        idle(); #1;
        n_checks++;
        if (busy_vec[9] !== 1'b0 || rd_busy !== 2'b00)
            $display("FAIL wb_clear vec9=%b rd_busy=%b want 0/00", busy_vec[9], rd_busy);
        else n_pass++;
        alloc_en = 1'b1; alloc_addr = 5'd9; we = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h77, 32'h0};
        tick();
        idle(); #1;
        n_checks++;
        if (busy_vec[9] !== 1'b1 || rd_data[0 +: 32] !== 32'h77)
            $display("FAIL alloc_and_write vec9=%b data=%h want 1/77", busy_vec[9], rd_data[0 +: 32]);
        else n_pass++;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        tick();
        idle(); rd_addr = {5'd0, 5'd0}; #1;
        n_checks++;
        if (busy_vec[0] !== 1'b0 || rd_busy !== 2'b00)
            $display("FAIL alloc_x0 vec0=%b rd_busy=%b want 0/00", busy_vec[0], rd_busy);
        else n_pass++;
        $display("test_scoreboard: alloc/writeback on x9 checked");
    endtask

    task automatic test_reset_mid();
        idle(); alloc_en = 1'b1; alloc_addr = 5'd4;
        tick();
        idle(); rst = 1'b1;
        tick();
        idle(); rd_addr = {5'd4, 5'd4}; #1;
        n_checks++;
        if (busy_vec !== 32'h0 || rd_data !== 64'h0 || rd_busy !== 2'b00)
            $display("FAIL reset_mid vec=%h data=%h busy=%b want 0", busy_vec, rd_data, rd_busy);
        else n_pass++;
        we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h5};
        tick();
        idle(); #1;
        n_checks++;
        if (rd_data !== {32'h5, 32'h5} || rd_busy !== 2'b00 || busy_vec[4] !== 1'b0)
            $display("FAIL reset_mid_write data=%h busy=%b want 5/00", rd_data, rd_busy);
        else n_pass++;
        $display("test_reset_mid: x4 pending bit discarded");
    endtask

    task automatic test_random();
        logic [31:0] e0, e1;
        for (int c = 0; c < 300; c++) begin
            idle();
            rst        = ($urandom_range(0, 49) == 0);
            we         = 2'($urandom_range(0, 3));
            waddr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata      = {$urandom, $urandom};
            alloc_en   = ($urandom_range(0, 2) == 0);
            alloc_addr = 5'($urandom_range(0, 7));
            rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            #1;
            for (int k = 0; k < 2; k++) begin
                e0 = exp_rd(rd_addr[k*AW +: AW], 1'b1);
                e1 = exp_rd(rd_addr[k*AW +: AW], 1'b0);
                n_checks++;
                if (rd_data[k*32 +: 32] !== e0 || rd_data_nb[k*32 +: 32] !== e1)
                    $display("FAIL rand_data cyc=%0d port=%0d got %h/%h want %h/%h",
                             c, k, rd_data[k*32 +: 32], rd_data_nb[k*32 +: 32], e0, e1);
                else n_pass++;
                n_checks++;
                if (rd_busy[k] !== exp_rbusy(rd_addr[k*AW +: AW], 1'b1) ||
                    rd_busy_nb[k] !== exp_rbusy(rd_addr[k*AW +: AW], 1'b0))
                    $display("FAIL rand_busy cyc=%0d port=%0d got %b/%b", c, k, rd_busy[k], rd_busy_nb[k]);
                else n_pass++;
            end
            n_checks++;
            if (busy_vec !== exp_bvec() || busy_vec_nb !== exp_bvec())
                $display("FAIL rand_vec cyc=%0d got %h/%h want %h", c, busy_vec, busy_vec_nb, exp_bvec());
            else n_pass++;
            $display("rand cyc=%0d rst=%b we=%b waddr=%h alloc=%b@%0d rd_addr=%h rd_data=%h",
                     c, rst, we, waddr, alloc_en, alloc_addr, rd_addr, rd_data);
            tick();
        end
    endtask

    initial begin
        idle(); rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
        #2;
        test_reset();
        test_write_read();
        test_bypass();
        test_dual_write();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
